// File: rtl/instruction_fetch_pkg.sv
// Shared constants, widths and buffer occupancy encoding for the instruction fetch stage.
package instruction_fetch_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int ENTRY_W = PC_W + INSTR_W;

    localparam logic [3:0]         OP_JUMP = 4'b0101;
    localparam logic [INSTR_W-1:0] OP_NOP  = 16'h0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } fifo_state_t;

    // Direct jumps carry their absolute target in the low byte.
    function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
        return instr[15:12] == OP_JUMP;
    endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: two-entry skid FIFO tracked by an EMPTY/ONE/FULL occupancy FSM.
module fetch_buffer
    import instruction_fetch_pkg::*;
#(
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output fifo_state_t      state
);

    logic [WIDTH-1:0] tail;

    // The head register is cleared whenever the buffer drains, so it reads zero when EMPTY.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= ST_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (push) begin
                        head  <= din;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        head <= din;
                    end else if (push) begin
                        tail  <= din;
                        state <= ST_FULL;
                    end else if (pop) begin
                        head  <= '0;
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= din;
                        end else begin
                            tail  <= '0;
                            state <= ST_ONE;
                        end
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    assign valid = (state != ST_EMPTY);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register, redirect control and a 2-entry output buffer.
// Optional jump predecode is enabled by defining FETCH_JUMP_PREDECODE_EN.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 8'h00,
    parameter int              IMEM_WORDS = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic [PC_W-1:0]    imem_pc,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc
);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    next_pc;
    logic               push;
    logic               pop;
    fifo_state_t        state;
    logic [ENTRY_W-1:0] head;

    assign imem_pc = fetch_pc;
    assign pop     = if_valid && if_ready;
    // A simultaneous pop frees a slot, so a FULL buffer still accepts a new word.
    assign push    = !redirect_valid && (state != ST_FULL || pop);

`ifdef FETCH_JUMP_PREDECODE_EN
    assign next_pc = is_jump(imem_instr) ? imem_instr[PC_W-1:0] : fetch_pc + 8'd1;
`else
    assign next_pc = fetch_pc + 8'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (push) begin
            fetch_pc <= next_pc;
        end
    end

    fetch_buffer #(
        .WIDTH(ENTRY_W)
    ) u_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({fetch_pc, imem_instr}),
        .valid (if_valid),
        .head  (head),
        .state (state)
    );

    assign if_pc    = head[ENTRY_W-1 -: PC_W];
    assign if_instr = head[INSTR_W-1:0];

    // Memory beyond the populated range must read back as NOP.
    a_nop_beyond_imem : assert property (@(posedge clk) disable iff (reset)
        (int'(fetch_pc) >= IMEM_WORDS) |-> (imem_instr == OP_NOP));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, jump sequence, random vs queue model.
module tb_instruction_fetch;

    localparam logic [7:0] RESET_PC   = 8'h00;
    localparam int         IMEM_WORDS = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  imem_pc;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [7:0]  if_pc;

    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } ent_t;

    ent_t       model_q[$];
    logic [7:0] model_pc;

    typedef struct {
        logic        rst;
        logic        redir;
        logic [7:0]  rpc;
        logic        rdy;
        logic        ev;
        logic [7:0]  epc;
        logic [15:0] ei;
        logic [7:0]  eimem;
    } vec_t;

    vec_t tbl[27];

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_pc];

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_pc       (imem_pc),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    // Queue model: the buffer is a list of {pc, instr}; the PC follows the sequential/jump rules.
    task automatic modelStep(input logic rst, input logic redir, input logic [7:0] rpc, input logic rdy);
        bit   do_pop;
        bit   do_push;
        ent_t e;
        if (rst) begin
            model_q.delete();
            model_pc = RESET_PC;
        end else begin
            do_pop  = (model_q.size() > 0) && rdy;
            do_push = !redir && ((model_q.size() < 2) || do_pop);
            e.pc    = model_pc;
            e.instr = mem[model_pc];
            if (do_pop) void'(model_q.pop_front());
            if (redir) begin
                model_q.delete();
                model_pc = rpc;
            end else if (do_push) begin
                model_q.push_back(e);
`ifdef FETCH_JUMP_PREDECODE_EN
                if (e.instr[15:12] == 4'b0101) model_pc = e.instr[7:0];
                else model_pc = model_pc + 8'd1;
`else
                model_pc = model_pc + 8'd1;
`endif
            end
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic redir, input logic [7:0] rpc, input logic rdy);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = rdy;
        modelStep(rst, redir, rpc, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic checkOutput(input string tag, input logic ev, input logic [7:0] epc,
                               input logic [15:0] ei, input logic [7:0] eimem);
        cmp({tag, " if_valid"}, {15'd0, if_valid}, {15'd0, ev});
        cmp({tag, " if_pc"}, {8'd0, if_pc}, {8'd0, epc});
        cmp({tag, " if_instr"}, if_instr, ei);
        cmp({tag, " imem_pc"}, {8'd0, imem_pc}, {8'd0, eimem});
    endtask

    task automatic checkModel(input string tag);
        if (model_q.size() > 0)
            checkOutput(tag, 1'b1, model_q[0].pc, model_q[0].instr, model_pc);
        else
            checkOutput(tag, 1'b0, 8'h00, 16'h0000, model_pc);
    endtask

    initial begin
        logic [7:0] seq [7];
        logic [7:0] rpc;

        for (int i = 0; i < 256; i++) mem[i] = (i < IMEM_WORDS) ? 16'hA000 + 16'(i) : 16'h0000;

        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'hA000, 8'h01};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 16'hA001, 8'h02};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 16'hA002, 8'h03};
        tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 16'hA003, 8'h04};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 16'hA004, 8'h05};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 16'hA005, 8'h06};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'hA000, 8'h01};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'hA000, 8'h02};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'hA000, 8'h02};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'hA000, 8'h02};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'hA000, 8'h02};
        tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 16'hA001, 8'h03};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 16'hA002, 8'h04};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 16'hA003, 8'h05};
        tbl[16] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h03};
        tbl[17] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 16'hA003, 8'h04};
        tbl[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 16'hA004, 8'h05};
        tbl[19] = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 16'h0000, 8'hFF};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 16'h0000, 8'h00};
        tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'hA000, 8'h01};
        tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 16'hA000, 8'h02};
        tbl[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00};
        tbl[24] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'hA000, 8'h01};
        tbl[25] = '{1'b1, 1'b1, 8'h20, 1'b1, 1'b0, 8'h00, 16'h0000, 8'h00};
        tbl[26] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 16'hA000, 8'h01};

        $display("[TB] directed vector table");
        for (int i = 0; i < 27; i++) begin
            applyStimulus(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy);
            checkOutput($sformatf("vec%0d", i), tbl[i].ev, tbl[i].epc, tbl[i].ei, tbl[i].eimem);
        end

        $display("[TB] jump predecode sequence");
        mem[5] = 16'h5003;
`ifdef FETCH_JUMP_PREDECODE_EN
        seq = '{8'h04, 8'h05, 8'h03, 8'h04, 8'h05, 8'h03, 8'h04};
`else
        seq = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
`endif
        applyStimulus(1'b0, 1'b1, 8'h04, 1'b1);
        checkOutput("jmp_redir", 1'b0, 8'h00, 16'h0000, 8'h04);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("jmp%0d", k), 1'b1, seq[k],
                        (seq[k] == 8'h05) ? 16'h5003 : 16'hA000 + {8'd0, seq[k]}, seq[k+1]);
        end
        mem[5] = 16'hA005;

        $display("[TB] random stimulus against model");
        mem[9] = 16'h5002;
        for (int n = 0; n < 400; n++) begin
            rpc = ($urandom_range(0, 9) == 0) ? 8'hFE + 8'($urandom_range(0, 1))
                                                : 8'($urandom_range(0, 40));
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0, rpc,
                          $urandom_range(0, 3) != 0);
            checkModel($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
